mul_arb: RTL and testbench

- Arbiter and sequencer that shares one pipelined 12-bit modular multiplier (`mul_reduce`, q = 3329, fixed 4-cycle latency, no stall) among N requesters, e.g. the NTT butterfly units and pointwise-multiply engines.
- Accepts at most one operand pair per cycle via valid/ready.
- Tracks the owner of each in-flight product with a tag pipeline matched to the multiplier latency.
- Returns each reduced result, registered, to the originating requester.

---
 rtl/kyber_pkg.sv | 17 +
 rtl/mul_reduce.sv | 29 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mul_arb.sv | 125 ++++++++++++
 tb/tb_mul_arb.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and the coefficient type used by the
// multiplier datapath and its arbiter.
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int COEF_W    = 12;
  localparam int MUL_LAT   = 4;
  // floor(2^24 / q); every 12x12 product fits below 2^24
  localparam int BARRETT_M = 5039;

  typedef logic [COEF_W-1:0] coef_t;

  function automatic logic [13:0] cond_sub_q(input logic [13:0] x);
    return (x >= 14'(KYBER_Q)) ? (x - 14'(KYBER_Q)) : x;
  endfunction

endpackage

// File: rtl/mul_reduce.sv
// Pipelined a*b mod q (q = 3329) using Barrett reduction; fixed 4-cycle
// latency from a/b to res, no stall, no reset on the datapath.
module mul_reduce
  import kyber_pkg::*;
(
  input  logic  clk,
  input  coef_t a,
  input  coef_t b,
  output coef_t res
);

  logic [23:0] p_q;
  logic [23:0] p2_q;
  logic [12:0] qe_q;
  logic [13:0] r_q;
  coef_t       res_q;

  // Barrett estimate may undershoot the true quotient by up to 2, so r < 3q
  always_ff @(posedge clk) begin
    p_q   <= 24'(a) * 24'(b);
    p2_q  <= p_q;
    qe_q  <= 13'((37'(p_q) * 37'(BARRETT_M)) >> 24);
    r_q   <= 14'(25'(p2_q) - 25'(qe_q) * 25'(KYBER_Q));
    res_q <= 12'(cond_sub_q(cond_sub_q(r_q)));
  end

  assign res = res_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request scanning upward from ptr_i
// modulo N. en_i = 0 suppresses every grant.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic           en_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_vld_o
);

  logic [IDW-1:0] idx_s;

  always_comb begin
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    idx_s     = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = IDW'((int'(ptr_i) + k) % N);
      if (en_i && !gnt_vld_o && req_i[idx_s]) begin
        gnt_o[idx_s] = 1'b1;
        gnt_id_o     = idx_s;
        gnt_vld_o    = 1'b1;
      end else begin
        gnt_vld_o = gnt_vld_o;
      end
    end
  end

endmodule

// File: rtl/mul_arb.sv
// Shares one mul_reduce among N requesters; a tag pipeline routes each result
// back to its owner. Define MUL_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mul_arb
  import kyber_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*COEF_W-1:0] req_a,
  input  logic [N*COEF_W-1:0] req_b,
  output logic [N-1:0]      rsp_valid,
  output coef_t             rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  logic [IDW-1:0] ptr_s;
  logic [IDW-1:0] gnt_id_s;
  logic           gnt_vld_s;
  coef_t          a_s, b_s, res_s;

  logic [MUL_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]     tag_id_q [MUL_LAT];
  logic [N-1:0]       rsp_valid_q, rsp_valid_d;
  coef_t              rsp_data_q, rsp_data_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req_i    (req_valid),
    .en_i     (!hold),
    .ptr_i    (ptr_s),
    .gnt_o    (req_ready),
    .gnt_id_o (gnt_id_s),
    .gnt_vld_o(gnt_vld_s)
  );

`ifdef MUL_ARB_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_s) begin
      ptr_d = (gnt_id_s == IDW'(N - 1)) ? '0 : gnt_id_s + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_s = ptr_q;
`endif

  // req_ready is one-hot or zero, so an AND-OR mux yields zero with no grant
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < N; i++) begin
      a_s = a_s | (req_a[i*COEF_W +: COEF_W] & {COEF_W{req_ready[i]}});
      b_s = b_s | (req_b[i*COEF_W +: COEF_W] & {COEF_W{req_ready[i]}});
    end
  end

  mul_reduce u_mul (
    .clk(clk),
    .a  (a_s),
    .b  (b_s),
    .res(res_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_id_q[s] <= '0;
    end else begin
      tag_vld_q   <= {tag_vld_q[MUL_LAT-2:0], gnt_vld_s};
      tag_id_q[0] <= gnt_id_s;
      for (int s = 1; s < MUL_LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    for (int i = 0; i < N; i++) begin
      rsp_valid_d[i] = tag_vld_q[MUL_LAT-1] && (tag_id_q[MUL_LAT-1] == IDW'(i));
    end
    if (tag_vld_q[MUL_LAT-1]) begin
      rsp_data_d = res_s;
      rsp_id_d   = tag_id_q[MUL_LAT-1];
    end else begin
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_mul_arb.sv
// Self-checking bench for mul_arb: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_mul_arb;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int Q   = 3329;
  localparam int LAT = 5;

  logic              clk;
  logic              rst;
  logic              hold;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*12-1:0]   req_a;
  logic [N*12-1:0]   req_b;
  logic [N-1:0]      rsp_valid;
  logic [11:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  mul_arb #(.N(N), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int id;
    int data;
  } exp_t;

  exp_t pend[$];
  int   m_ptr;
  int   cyc;
  int   n_chk;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    hold      = 1'b0;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i]       = 1'b1;
    req_a[12*i +: 12]  = 12'(a);
    req_b[12*i +: 12]  = 12'(b);
  endtask

  // Check one cycle against the model, then advance to the next negedge.
  task automatic cycle();
    int           g;
    int           idx;
    int           av;
    int           bv;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_vld;
    #1;
    g = -1;
    if (!hold) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(pend.size() > 0));
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_vld = '0;
      exp_vld[pend[0].id] = 1'b1;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
      chk("rsp_data", 32'(rsp_data), 32'(pend[0].data));
      chk("rsp_id", 32'(rsp_id), 32'(pend[0].id));
      void'(pend.pop_front());
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'h0);
    end
    if (g >= 0) begin
      av = int'(req_a[12*g +: 12]);
      bv = int'(req_b[12*g +: 12]);
      pend.push_back('{cyc + LAT, g, (av * bv) % Q});
`ifndef MUL_ARB_FIXED_PRIO_EN
      m_ptr = (g + 1) % N;
`endif
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_req();
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    m_ptr = 0;
    cyc   = 0;
  endtask

  task automatic idle(input int n);
    clear_req();
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_ptr  = 0;
    cyc    = 0;
    rst    = 1'b1;
    clear_req();
    @(negedge clk);
    do_reset();

    // single request from requester 2: 2*3
    idle(3);
    set_req(2, 2, 3);
    cycle();
    idle(7);

    // reduction corners, back to back from requester 0
    set_req(0, 3328, 3328); cycle();
    set_req(0, 3328, 2);    cycle();
    set_req(0, 1000, 2000); cycle();
    idle(7);

    // fairness: all valid for 8 cycles from reset
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
      cycle();
    end
    idle(7);

    // hold during cycles 3..5 with all requesters valid
    do_reset();
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
      hold = (k >= 3 && k <= 5);
      cycle();
    end
    idle(7);

    // reset two cycles after three transfers: nothing may come back
    for (int k = 0; k < 3; k++) begin
      set_req(k, 100 + k, 200 + k);
      cycle();
      clear_req();
    end
    idle(2);
    do_reset();
    idle(7);
    set_req(1, 17, 17);
    cycle();
    idle(7);

    // random traffic, including requesters dropping valid without a grant
    for (int k = 0; k < 300; k++) begin
      clear_req();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) set_req(i, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
      end
      hold = ($urandom_range(0, 7) == 0);
      cycle();
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
